// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave front-end: FSM state encoding and
// the two-bit command codes carried at the head of every frame.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage : spi_slave_pkg

// File: rtl/spi_tx_shifter.sv
// Load/shift serialiser for the MISO path. A load presents the first bit
// immediately on the registered output; each shift presents the next one.
// With neither load nor shift asserted the output parks at 0.
module spi_tx_shifter #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_bit
);

    logic [W-1:0] r_data;
    logic         r_bit;

    // Serialise the captured word, one bit per shift, idling low otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the holding register is cleared along with the output so
            // no stale word can ever be shifted out after a reset.
            r_data <= '0;
            r_bit  <= 1'b0;
        end else if (i_load) begin
            // NOTE: non-blocking assignments here; every right-hand side reads
            // the pre-edge value, so load and shift never race each other.
            r_bit  <= MSB_FIRST ? i_data[W-1] : i_data[0];
            r_data <= MSB_FIRST ? (i_data << 1) : (i_data >> 1);
        end else if (i_shift) begin
            r_bit  <= MSB_FIRST ? r_data[W-1] : r_data[0];
            r_data <= MSB_FIRST ? (r_data << 1) : (r_data >> 1);
        end else begin
            r_bit  <= 1'b0;
        end
    end

    assign o_bit = r_bit;

endmodule : spi_tx_shifter

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM path. Deserialises
// {cmd[1:0], payload} frames from MOSI, hands them to the RAM controller via
// rx_data/rx_valid, and serialises RAM read data onto MISO after a legal
// RD_ADDR -> RD_DATA sequence. Aborted or out-of-sequence frames raise
// frame_err for one cycle.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int FW = DATA_W + 2;
    localparam int CW = $clog2(FW);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   r_shift;
    logic            r_full;
    logic            r_rd_addr_ok;
    logic [FW-1:0]   r_rx_data;
    logic            r_rx_valid;
    logic            r_frame_err;

    logic [CW-1:0]   w_pos;
    logic [1:0]      w_cmd;
    logic            w_load;
    logic            w_shift;

    // Map the down-counter onto a frame bit position for the chosen bit order.
    always_comb begin
        w_pos = MSB_FIRST ? r_cnt : (CW'(FW - 1) - r_cnt);
    end

    assign w_cmd = r_shift[FW-1 -: 2];

    // Drive the MISO serialiser: load on accepted read data, shift while bits remain.
    always_comb begin
        w_load  = (r_state == ST_WAIT_TX) && !SS_n && tx_valid;
        w_shift = (r_state == ST_TX) && !SS_n && (r_cnt != '0);
    end

    // Frame FSM with receive shifter, bit counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_full       <= 1'b0;
            r_rd_addr_ok <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            // Both status outputs are single-cycle pulses; any branch below
            // that wants one overrides these defaults.
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_full  <= 1'b0;
                    r_shift <= '0;
                    if (!SS_n) begin
                        r_state <= ST_RX;
                        r_cnt   <= CW'(FW - 1);
                    end
                end
                ST_RX: begin
                    if (r_full) begin
                        // Whole frame is in the shifter: publish and dispatch.
                        r_rx_data <= r_shift;
                        unique case (w_cmd)
                            CMD_RD_ADDR: begin
                                r_rx_valid   <= 1'b1;
                                r_rd_addr_ok <= 1'b1;
                                r_state      <= ST_DONE;
                            end
                            CMD_RD_DATA: begin
                                if (r_rd_addr_ok) begin
                                    r_rx_valid   <= 1'b1;
                                    r_rd_addr_ok <= 1'b0;
                                    r_state      <= ST_WAIT_TX;
                                end else begin
                                    r_frame_err <= 1'b1;
                                    r_state     <= ST_DONE;
                                end
                            end
                            default: begin
                                r_rx_valid <= 1'b1;
                                r_state    <= ST_DONE;
                            end
                        endcase
                    end else if (SS_n) begin
                        // Select dropped mid-frame: discard the partial word.
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_shift[w_pos] <= MOSI;
                        if (r_cnt == '0) begin
                            r_full <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                ST_WAIT_TX: begin
                    if (SS_n) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (tx_valid) begin
                        r_state <= ST_TX;
                        r_cnt   <= CW'(DATA_W - 1);
                    end
                end
                ST_TX: begin
                    if (SS_n) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (SS_n) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    spi_tx_shifter #(
        .W         (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (tx_data),
        .o_bit   (MISO)
    );

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != ST_IDLE);

endmodule : spi_slave_param

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: an 8-bit MSB-first instance and a
// 16-bit LSB-first instance. Expected frames and MISO bits are queued when
// stimulus is driven and popped when the DUT produces them.
module tb_spi_slave_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        miso;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    logic        ss_n16 = 1'b1;
    logic        mosi16 = 1'b0;
    logic        tx_valid16 = 1'b0;
    logic [15:0] tx_data16 = 16'h0000;
    logic        miso16;
    logic [17:0] rx_data16;
    logic        rx_valid16;
    logic        frame_err16;
    logic        busy16;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [9:0]  exp_rx_q[$];
    logic [17:0] exp_rx16_q[$];
    logic        exp_miso_q[$];
    logic [9:0]  last_rx;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (ss_n),
        .MOSI      (mosi),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .MISO      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (ss_n16),
        .MOSI      (mosi16),
        .tx_valid  (tx_valid16),
        .tx_data   (tx_data16),
        .MISO      (miso16),
        .rx_data   (rx_data16),
        .rx_valid  (rx_valid16),
        .frame_err (frame_err16),
        .busy      (busy16)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; ss_n = 1'b1; ss_n16 = 1'b1; tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi = frame[9-i];
        end
    endtask

    task automatic send_frame(input logic [9:0] frame, input bit push);
        @(negedge clk);
        ss_n = 1'b0;
        mosi = 1'b0;
        drive_bits(frame, 10);
        if (push) exp_rx_q.push_back(frame);
    endtask

    task automatic end_frame();
        @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
    endtask

    // Bounded wait for rx_valid or frame_err on the 8-bit DUT; lat=0 on timeout.
    task automatic wait_result(output int lat, output logic v, output logic e,
                               output logic m);
        lat = 0; v = 1'b0; e = 1'b0; m = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            m = m | miso;
            if (rx_valid || frame_err) begin
                lat = k; v = rx_valid; e = frame_err;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got=%b exp=0", miso); end
        n_cmp++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL reset_rx_data got=%h exp=000", rx_data); end
        n_cmp++; if ({rx_valid, frame_err} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got=%b exp=00", {rx_valid, frame_err}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if ({busy16, rx_data16} !== 19'h0) begin n_err++; $display("FAIL reset_dut16 got=%h exp=0", {busy16, rx_data16}); end
        last_rx = 10'h000;
    endtask

    task automatic test_rd_no_addr();
        int   lat;
        logic v, e, m;
        send_frame(10'h300, 1'b0);
        wait_result(lat, v, e, m);
        n_cmp++; if ({v, e} !== 2'b01) begin n_err++; $display("FAIL rdnoaddr_flags got=%b exp=01", {v, e}); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rdnoaddr_latency got=%0d exp=2", lat); end
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({miso, frame_err, rx_valid} !== 3'b000) begin n_err++; $display("FAIL rdnoaddr_quiet[%0d] got=%b exp=000", i, {miso, frame_err, rx_valid}); end
        end
        tx_valid = 1'b0;
        end_frame();
    endtask

    task automatic test_write();
        int         lat;
        logic       v, e, m;
        logic [9:0] exp;
        send_frame(10'h0A5, 1'b1);
        wait_result(lat, v, e, m);
        n_cmp++; if ({v, e, m} !== 3'b100) begin n_err++; $display("FAIL write_flags got=%b exp=100", {v, e, m}); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL write_latency got=%0d exp=2", lat); end
        exp = exp_rx_q.pop_front();
        last_rx = exp;
        n_cmp++; if (rx_data !== exp) begin n_err++; $display("FAIL write_rx_data got=%h exp=%h", rx_data, exp); end
        @(negedge clk);
        n_cmp++; if ({rx_valid, frame_err, miso, busy} !== 4'b0001) begin n_err++; $display("FAIL write_after got=%b exp=0001", {rx_valid, frame_err, miso, busy}); end
        end_frame();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_read_sequence();
        int         lat;
        logic       v, e, m;
        logic [9:0] exp;
        logic [7:0] word;
        logic       eb;
        send_frame(10'h23C, 1'b1);
        wait_result(lat, v, e, m);
        exp = exp_rx_q.pop_front();
        n_cmp++; if ({v, e} !== 2'b10 || rx_data !== exp) begin n_err++; $display("FAIL rdaddr_frame got=%b/%h exp=10/%h", {v, e}, rx_data, exp); end
        end_frame();
        send_frame(10'h300, 1'b1);
        wait_result(lat, v, e, m);
        exp = exp_rx_q.pop_front();
        last_rx = exp;
        n_cmp++; if ({v, e} !== 2'b10 || rx_data !== exp) begin n_err++; $display("FAIL rddata_frame got=%b/%h exp=10/%h", {v, e}, rx_data, exp); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({miso, busy} !== 2'b01) begin n_err++; $display("FAIL wait_tx_idle got=%b exp=01", {miso, busy}); end
        word = 8'hC3;
        tx_valid = 1'b1;
        tx_data  = word;
        for (int b = 7; b >= 0; b--) exp_miso_q.push_back(word[b]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            eb = exp_miso_q.pop_front();
            n_cmp++; if (miso !== eb) begin n_err++; $display("FAIL read_miso_bit[%0d] got=%b exp=%b", i, miso, eb); end
        end
        @(negedge clk);
        n_cmp++; if ({miso, frame_err, busy} !== 3'b001) begin n_err++; $display("FAIL read_miso_end got=%b exp=001", {miso, frame_err, busy}); end
        end_frame();
    endtask

    task automatic test_abort();
        int         lat;
        logic       v, e, m;
        logic [9:0] exp;
        @(negedge clk);
        ss_n = 1'b0;
        drive_bits(10'h155, 5);
        @(negedge clk);
        ss_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({frame_err, rx_valid, busy} !== 3'b100) begin n_err++; $display("FAIL abort_flags got=%b exp=100", {frame_err, rx_valid, busy}); end
        n_cmp++; if (rx_data !== last_rx) begin n_err++; $display("FAIL abort_rx_kept got=%h exp=%h", rx_data, last_rx); end
        @(negedge clk);
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL abort_one_pulse got=%b exp=0", frame_err); end
        send_frame(10'h1FF, 1'b1);
        wait_result(lat, v, e, m);
        exp = exp_rx_q.pop_front();
        last_rx = exp;
        n_cmp++; if ({v, e} !== 2'b10 || rx_data !== exp || lat !== 2) begin n_err++; $display("FAIL abort_next_frame got=%b/%h/%0d exp=10/%h/2", {v, e}, rx_data, lat, exp); end
        end_frame();
    endtask

    task automatic test_reset_mid_tx();
        int         lat;
        logic       v, e, m;
        logic [9:0] exp;
        logic [7:0] word;
        logic       eb;
        send_frame(10'h200, 1'b1);
        wait_result(lat, v, e, m);
        exp = exp_rx_q.pop_front();
        n_cmp++; if (rx_data !== exp) begin n_err++; $display("FAIL rst_tx_rdaddr got=%h exp=%h", rx_data, exp); end
        end_frame();
        send_frame(10'h311, 1'b1);
        wait_result(lat, v, e, m);
        exp = exp_rx_q.pop_front();
        n_cmp++; if ({v, rx_data} !== {1'b1, exp}) begin n_err++; $display("FAIL rst_tx_rddata got=%b/%h exp=1/%h", v, rx_data, exp); end
        word = 8'hA5;
        tx_valid = 1'b1;
        tx_data  = word;
        for (int b = 7; b >= 0; b--) exp_miso_q.push_back(word[b]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            eb = exp_miso_q.pop_front();
            n_cmp++; if (miso !== eb) begin n_err++; $display("FAIL rst_tx_bit[%0d] got=%b exp=%b", i, miso, eb); end
        end
        exp_miso_q.delete();
        rst_n = 1'b0;
        ss_n  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if ({miso, busy, rx_data} !== 12'h000) begin n_err++; $display("FAIL rst_tx_cleared got=%b/%b/%h exp=0/0/000", miso, busy, rx_data); end
        send_frame(10'h300, 1'b0);
        wait_result(lat, v, e, m);
        n_cmp++; if ({v, e} !== 2'b01) begin n_err++; $display("FAIL rst_tx_rdaddr_cleared got=%b exp=01", {v, e}); end
        end_frame();
    endtask

    task automatic test_lsb16();
        logic [17:0] frame;
        logic [17:0] exp;
        int          lat;
        frame = 18'h18001;
        @(negedge clk);
        ss_n16 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            mosi16 = frame[i];
        end
        exp_rx16_q.push_back(frame);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rx_valid16 || frame_err16) begin lat = k; break; end
        end
        n_cmp++; if ({rx_valid16, frame_err16} !== 2'b10 || lat !== 2) begin n_err++; $display("FAIL lsb16_flags got=%b/%0d exp=10/2", {rx_valid16, frame_err16}, lat); end
        exp = exp_rx16_q.pop_front();
        n_cmp++; if (rx_data16 !== exp) begin n_err++; $display("FAIL lsb16_rx_data got=%h exp=%h", rx_data16, exp); end
        @(negedge clk);
        ss_n16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({busy16, miso16} !== 2'b00) begin n_err++; $display("FAIL lsb16_idle got=%b exp=00", {busy16, miso16}); end
    endtask

    initial begin
        test_reset();
        test_rd_no_addr();
        test_write();
        test_read_sequence();
        test_abort();
        test_reset_mid_tx();
        test_lsb16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_slave_param
